// File: rtl/i2s_frame_sequencer.sv
// I2S transmitter: one-deep stereo pending buffer feeding a 64-BCK frame.
// Left word in the low-LRCK half, right word in the high half, one-BCK delay.
module i2s_frame_sequencer #(
  parameter int unsigned BCK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_valid,
  input  logic [15:0] i_data_l,
  input  logic [15:0] i_data_r,
  output logic        o_bck,
  output logic        o_lrck,
  output logic        o_sdata,
  output logic        o_ready,
  output logic        o_underflow,
  output logic        o_overrun
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(BCK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [31:0] frame;
  logic [15:0] pend_l;
  logic [15:0] pend_r;
  logic        full;

  logic        bck_edge;
  logic        bck_fall;
  logic        frame_start;
  logic [5:0]  bit_nxt;
  logic [4:0]  slot;
  logic [3:0]  idx;
  logic [4:0]  sel;
  logic        sd_nxt;

  assign o_ready = ~full;

  always_comb begin
    bck_edge    = (state == RUN) && i_enable && (div_cnt == DIV_LAST);
    bck_fall    = bck_edge && o_bck;
    bit_nxt     = bit_cnt + 6'd1;
    slot        = bit_nxt[4:0];
    frame_start = ((state == IDLE) && i_enable) ||
                  (bck_fall && (bit_cnt == 6'd63));
    // slot k carries bit 16-k; left word sits in frame[31:16]
    idx         = 4'(5'd16 - slot);
    sel         = {~bit_nxt[5], idx};
    sd_nxt      = 1'b0;
    if ((slot != 5'd0) && (slot <= 5'd16)) begin
      sd_nxt = frame[sel];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      frame       <= '0;
      pend_l      <= '0;
      pend_r      <= '0;
      full        <= 1'b0;
      o_bck       <= 1'b0;
      o_lrck      <= 1'b0;
      o_sdata     <= 1'b0;
      o_underflow <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_underflow <= 1'b0;
      o_overrun   <= 1'b0;

      unique case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          o_bck   <= 1'b0;
          o_lrck  <= 1'b0;
          o_sdata <= 1'b0;
          if (i_enable) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!i_enable) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            o_bck   <= 1'b0;
            o_lrck  <= 1'b0;
            o_sdata <= 1'b0;
          end else if (bck_edge) begin
            div_cnt <= '0;
            o_bck   <= ~o_bck;
            if (bck_fall) begin
              bit_cnt <= bit_nxt;
              o_lrck  <= bit_nxt[5];
              o_sdata <= sd_nxt;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (frame_start) begin
        frame       <= full ? {pend_l, pend_r} : 32'd0;
        o_underflow <= ~full;
      end

      // a strobe on a frame start refills the slot just emptied
      if (i_valid) begin
        pend_l    <= i_data_l;
        pend_r    <= i_data_r;
        full      <= 1'b1;
        o_overrun <= full && !frame_start;
      end else if (frame_start) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Directed bench for i2s_frame_sequencer at BCK_DIV=2.
// Frame slots are sampled on each BCK rise.
module tb_i2s_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        valid;
  logic [15:0] dl;
  logic [15:0] dr;
  logic        bck;
  logic        lrck;
  logic        sdata;
  logic        ready;
  logic        underflow;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int t = 0;
  int e0;
  int e1;
  logic [63:0] sd;
  logic [63:0] lr;
  int nb;

  localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0};

  i2s_frame_sequencer #(.BCK_DIV(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_enable   (enable),
    .i_valid    (valid),
    .i_data_l   (dl),
    .i_data_r   (dr),
    .o_bck      (bck),
    .o_lrck     (lrck),
    .o_sdata    (sdata),
    .o_ready    (ready),
    .o_underflow(underflow),
    .o_overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
    end
    #1;
  endtask

  task automatic wait_to(input int e);
    if (e > t) tick(e - t);
  endtask

  function automatic logic [63:0] sd_exp(input logic [15:0] l,
                                         input logic [15:0] r);
    logic [63:0] v;
    logic [15:0] w;
    int k;
    v = '0;
    for (int m = 0; m < 64; m++) begin
      k = m % 32;
      w = (m < 32) ? l : r;
      if (k >= 1 && k <= 16) v[m] = w[16-k];
    end
    return v;
  endfunction

  task automatic capture(input int f, output logic [63:0] s,
                         output logic [63:0] l, output int n);
    n = 0;
    s = '0;
    l = '0;
    for (int m = 0; m < 64; m++) begin
      wait_to(f + 4*m + 2);
      s[m] = sdata;
      l[m] = lrck;
      if (bck) n++;
    end
  endtask

  task automatic put(input logic [15:0] l, input logic [15:0] r);
    valid = 1'b1;
    dl = l;
    dr = r;
    tick(1);
    valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    valid = 1'b0;
    dl = '0;
    dr = '0;
    tick(2);
    check("rst_bck", 64'(bck), 64'd0);
    check("rst_lrck", 64'(lrck), 64'd0);
    check("rst_sdata", 64'(sdata), 64'd0);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_uflow", 64'(underflow), 64'd0);
    check("rst_ovr", 64'(overrun), 64'd0);
    rst_n = 1'b1;
    tick(1);

    put(16'hA5C3, 16'h0F01);
    check("wr_ready", 64'(ready), 64'd0);
    check("wr_ovr", 64'(overrun), 64'd0);

    enable = 1'b1;
    tick(1);
    e0 = t;
    check("ent_ready", 64'(ready), 64'd1);
    check("ent_uflow", 64'(underflow), 64'd0);
    check("ent_bck", 64'(bck), 64'd0);
    capture(e0, sd, lr, nb);
    check("f1_sdata", sd, sd_exp(16'hA5C3, 16'h0F01));
    check("f1_lrck", lr, LR_EXP);
    check("f1_bck", 64'(nb), 64'd64);

    wait_to(e0 + 256);
    check("f2_uflow", 64'(underflow), 64'd1);
    tick(1);
    check("f2_uflow_end", 64'(underflow), 64'd0);

    put(16'h1234, 16'h5678);
    check("ovr1_none", 64'(overrun), 64'd0);
    check("ovr1_ready", 64'(ready), 64'd0);
    wait_to(e0 + 300);
    put(16'h8001, 16'h7FFF);
    check("ovr2_pulse", 64'(overrun), 64'd1);
    tick(1);
    check("ovr2_end", 64'(overrun), 64'd0);

    wait_to(e0 + 512);
    check("f3_uflow", 64'(underflow), 64'd0);
    check("f3_ready", 64'(ready), 64'd1);
    capture(e0 + 512, sd, lr, nb);
    check("f3_sdata", sd, sd_exp(16'h8001, 16'h7FFF));
    check("f3_lrck", lr, LR_EXP);

    put(16'hC001, 16'h3FFE);
    put(16'h0001, 16'hFFFF);
    check("fs_t", 64'(t), 64'(e0 + 768));
    check("fs_ovr", 64'(overrun), 64'd0);
    check("fs_ready", 64'(ready), 64'd0);
    check("fs_uflow", 64'(underflow), 64'd0);
    capture(e0 + 768, sd, lr, nb);
    check("f4_sdata", sd, sd_exp(16'hC001, 16'h3FFE));
    check("f4_ready", 64'(ready), 64'd0);

    wait_to(e0 + 1024);
    check("f5_ready", 64'(ready), 64'd1);
    check("f5_uflow", 64'(underflow), 64'd0);
    wait_to(e0 + 1100);
    put(16'h8000, 16'h0001);
    check("f5_wr_ready", 64'(ready), 64'd0);

    wait_to(e0 + 1024 + 160);
    check("c40_lrck", 64'(lrck), 64'd1);
    check("c40_sdata", 64'(sdata), 64'd1);
    check("c40_bck", 64'(bck), 64'd0);
    enable = 1'b0;
    tick(1);
    check("ab_bck", 64'(bck), 64'd0);
    check("ab_lrck", 64'(lrck), 64'd0);
    check("ab_sdata", 64'(sdata), 64'd0);
    check("ab_ready", 64'(ready), 64'd0);
    tick(5);
    check("idle_bck", 64'(bck), 64'd0);
    check("idle_ready", 64'(ready), 64'd0);

    enable = 1'b1;
    tick(1);
    e1 = t;
    check("re_uflow", 64'(underflow), 64'd0);
    check("re_ready", 64'(ready), 64'd1);
    capture(e1, sd, lr, nb);
    check("f6_sdata", sd, sd_exp(16'h8000, 16'h0001));
    check("f6_lrck", lr, LR_EXP);
    check("f6_bck", 64'(nb), 64'd64);

    put(16'h5555, 16'h8000);
    wait_to(e1 + 256);
    check("f7_ready", 64'(ready), 64'd1);
    check("f7_uflow", 64'(underflow), 64'd0);
    tick(1);
    put(16'h1111, 16'h2222);
    wait_to(e1 + 256 + 4*33 + 2);
    check("pre_bck", 64'(bck), 64'd1);
    check("pre_lrck", 64'(lrck), 64'd1);
    check("pre_sdata", 64'(sdata), 64'd1);
    check("pre_ready", 64'(ready), 64'd0);

    #3;
    rst_n = 1'b0;
    #1;
    check("ar_bck", 64'(bck), 64'd0);
    check("ar_lrck", 64'(lrck), 64'd0);
    check("ar_sdata", 64'(sdata), 64'd0);
    check("ar_ready", 64'(ready), 64'd1);
    check("ar_uflow", 64'(underflow), 64'd0);
    check("ar_ovr", 64'(overrun), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
